// File: rtl/serial_shift_reg.sv
// Parallel-load, LSB-first serializer that streams a WIDTH-bit operand followed by
// EXT sign- or zero-extension bits, with back-to-back reload on the final bit.
module serial_shift_reg #(
   parameter int WIDTH  = 8,
   parameter int EXT    = 8,
   parameter bit SIGNED = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] din,
   input  logic             en,
   output logic             ready,
   output logic             sout,
   output logic             svalid,
   output logic             last,
   output logic             done
);

   localparam int N  = WIDTH + EXT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             done_q, done_d;

   logic is_shift, last_int, accept, fill;

   always_comb begin
      is_shift = (state_q == SHIFT);
      last_int = is_shift && (cnt_q == LAST_IDX);
      ready    = !is_shift || (en && last_int);
      accept   = start && ready;
      // Replicating the MSB makes every bit past WIDTH equal the operand sign.
      fill     = SIGNED ? shreg_q[WIDTH-1] : 1'b0;

      state_d  = state_q;
      shreg_d  = shreg_q;
      cnt_d    = cnt_q;
      done_d   = is_shift && en && last_int;

      if (accept) begin
         state_d = SHIFT;
         shreg_d = din;
         cnt_d   = '0;
      end else if (is_shift && en) begin
         if (last_int) begin
            state_d = IDLE;
         end else begin
            shreg_d = {fill, shreg_q[WIDTH-1:1]};
            cnt_d   = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   assign svalid = is_shift;
   assign sout   = is_shift ? shreg_q[0] : 1'b0;
   assign last   = last_int;
   assign done   = done_q;

endmodule

// File: tb/tb_serial_shift_reg.sv
// Bench for serial_shift_reg: signed and unsigned instances share stimulus and are
// checked every cycle against a stream-level model (operand, bit index, active flag).
module tb_serial_shift_reg;
   localparam int W = 8;
   localparam int E = 8;
   localparam int N = W + E;

   logic clk = 1'b0;
   logic rst, start, en;
   logic [W-1:0] din;
   logic rdy_s, sout_s, sv_s, last_s, done_s;
   logic rdy_u, sout_u, sv_u, last_u, done_u;

   int errors = 0;
   int checks = 0;

   // model state
   bit         m_act = 1'b0;
   int         m_idx = 0;
   bit [W-1:0] m_op = '0;
   bit         m_done = 1'b0;

   // bit capture for directed scenarios
   bit [N-1:0] cap_s, cap_u;
   int         ncons;

   always #5 clk = ~clk;

   serial_shift_reg #(.WIDTH(W), .EXT(E), .SIGNED(1'b1)) u_s (
      .clk(clk), .rst(rst), .start(start), .din(din), .en(en),
      .ready(rdy_s), .sout(sout_s), .svalid(sv_s), .last(last_s), .done(done_s));

   serial_shift_reg #(.WIDTH(W), .EXT(E), .SIGNED(1'b0)) u_u (
      .clk(clk), .rst(rst), .start(start), .din(din), .en(en),
      .ready(rdy_u), .sout(sout_u), .svalid(sv_u), .last(last_u), .done(done_u));

   function automatic bit exp_bit(bit [W-1:0] op, int idx, bit sgn);
      if (idx < W) return op[idx];
      return sgn ? op[W-1] : 1'b0;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock: drive inputs, check outputs against the model, clock, advance model.
   task automatic cyc(input logic s, input logic [W-1:0] d, input logic e, input logic r);
      bit e_last, e_rdy;
      start = s; din = d; en = e; rst = r;
      #1;
      e_last = m_act && (m_idx == N - 1);
      e_rdy  = !m_act || (e && e_last);
      check("ready_s",  rdy_s,  e_rdy);
      check("ready_u",  rdy_u,  e_rdy);
      check("svalid_s", sv_s,   m_act);
      check("svalid_u", sv_u,   m_act);
      check("last_s",   last_s, e_last);
      check("last_u",   last_u, e_last);
      check("done_s",   done_s, m_done);
      check("done_u",   done_u, m_done);
      check("sout_s",   sout_s, m_act ? exp_bit(m_op, m_idx, 1'b1) : 1'b0);
      check("sout_u",   sout_u, m_act ? exp_bit(m_op, m_idx, 1'b0) : 1'b0);
      if (!r && m_act && e) begin
         cap_s[ncons % N] = sout_s;
         cap_u[ncons % N] = sout_u;
         ncons++;
      end
      @(posedge clk);
      if (r) begin
         m_act = 1'b0; m_idx = 0; m_done = 1'b0;
      end else begin
         m_done = m_act && e && e_last;
         if (s && e_rdy) begin
            m_act = 1'b1; m_op = d; m_idx = 0;
         end else if (m_act && e) begin
            if (e_last) m_act = 1'b0;
            else m_idx++;
         end
      end
      #1;
   endtask

   initial begin
      start = 1'b0; din = '0; en = 1'b0; rst = 1'b1;
      ncons = 0;
      cyc(0, 8'h00, 0, 1);
      cyc(0, 8'h00, 0, 1);
      cyc(0, 8'h00, 0, 0);

      // 0x85 streamed with en held high
      ncons = 0;
      cyc(1, 8'h85, 1, 0);
      for (int i = 0; i < N; i++) cyc(0, 8'h00, 1, 0);
      cyc(0, 8'h00, 1, 0);
      check("stream_0x85_signed", cap_s, 16'hFF85);
      check("stream_0x85_unsigned", cap_u, 16'h0085);

      // 0x03 with a three-cycle pause after bit 2
      ncons = 0;
      cyc(1, 8'h03, 1, 0);
      cyc(0, 8'h00, 1, 0);
      cyc(0, 8'h00, 1, 0);
      for (int i = 0; i < 3; i++) cyc(0, 8'h00, 0, 0);
      for (int i = 0; i < N - 2; i++) cyc(0, 8'h00, 1, 0);
      cyc(0, 8'h00, 1, 0);
      check("pause_consumed", ncons, N);
      check("pause_stream_signed", cap_s, 16'h0003);

      // start held: 0x7F then 0x80 presented on the last bit, back-to-back
      cyc(1, 8'h7F, 1, 0);
      for (int i = 0; i < N - 1; i++) cyc(1, 8'h7F, 1, 0);
      cyc(1, 8'h80, 1, 0);
      ncons = 0;
      for (int i = 0; i < N; i++) cyc(0, 8'h00, 1, 0);
      check("second_stream_signed", cap_s, 16'hFF80);
      cyc(0, 8'h00, 1, 0);

      // start mid-stream is ignored
      ncons = 0;
      cyc(1, 8'h5A, 1, 0);
      for (int i = 0; i < N; i++) cyc((i == 4), 8'hFF, 1, 0);
      check("ignored_start_stream", cap_u, 16'h005A);
      cyc(0, 8'h00, 1, 0);

      // reset after bit 5, then a fresh stream
      cyc(1, 8'hC6, 1, 0);
      for (int i = 0; i < 5; i++) cyc(0, 8'h00, 1, 0);
      cyc(0, 8'h00, 1, 1);
      ncons = 0;
      cyc(1, 8'hC6, 1, 0);
      for (int i = 0; i < N; i++) cyc(0, 8'h00, 1, 0);
      check("post_reset_stream", cap_s, 16'hFFC6);

      // randomized traffic
      for (int i = 0; i < 400; i++)
         cyc(1'($urandom_range(0, 3) == 0), 8'($urandom), 1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 60) == 0));
      for (int i = 0; i < N + 2; i++) cyc(0, 8'h00, 1, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "bench timeout");
   end
endmodule
